// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared constants and types for the registered decode stage.
// Holds opcode class codes (instr[6:2]), funct3/funct7 values used by the
// legality checks, wb_mux_sel / imm_type encodings, and the decoded bundle.
`timescale 1ns/1ps
package msrv32_pkg;

  // Opcode classes, instr[6:2]
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // funct3 values referenced by legality checks
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_RSV_010 = 3'b010;
  localparam logic [2:0] F3_RSV_011 = 3'b011;
  localparam logic [2:0] F3_RSV_110 = 3'b110;
  localparam logic [2:0] F3_RSV_111 = 3'b111;
  localparam logic [2:0] F3_PRIV    = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Write-back select: bit0 load/auipc/jal/jalr, bit1 csr/jal/jalr, bit2 muldiv
  localparam logic [2:0] WB_ALU    = 3'b000;
  localparam logic [2:0] WB_LU     = 3'b001;
  localparam logic [2:0] WB_CSR    = 3'b010;
  localparam logic [2:0] WB_PC4    = 3'b011;
  localparam logic [2:0] WB_MULDIV = 3'b100;

  // Immediate type: bit0 op_imm/load/jalr/branch/jal, bit1 store/branch/csr,
  // bit2 lui/auipc/jal/csr
  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;
  localparam logic [2:0] IMM_CSR  = 3'b110;

  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic [3:0] alu_opcode;
    logic       muldiv_en;
    logic [2:0] muldiv_op;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       mem_rd_req;
    logic       mem_wr_req;
    logic       alu_src;
    logic       iadder_src;
    logic       rf_wr_en;
    logic       csr_wr_en;
    logic [2:0] csr_op;
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_fence;
    logic       illegal;
  } dec_bundle_t;

endpackage

// File: rtl/msrv32_dec_core.sv
// msrv32_dec_core: purely combinational RV32I(+M) decoder.
// Ports: instr_in (32-bit instruction) -> bundle_out (dec_bundle_t).
// Parameters: EN_M enables MUL/DIV decode, EN_CSR enables CSR decode.
`timescale 1ns/1ps
module msrv32_dec_core
  import msrv32_pkg::*;
#(
  parameter int unsigned EN_M   = 1,
  parameter int unsigned EN_CSR = 1
) (
  input  logic [31:0] instr_in,
  output dec_bundle_t bundle_out
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       is_lui, is_auipc, is_fence, is_system, is_csr, is_shift, is_md;
  logic       illegal, ok;

  always_comb begin
    opc = instr_in[6:2];
    f3  = instr_in[14:12];
    f7  = instr_in[31:25];

    // A non-11 low pair disqualifies every class, making the word illegal.
    is_op     = (instr_in[1:0] == 2'b11) && (opc == OPC_OP);
    is_op_imm = (instr_in[1:0] == 2'b11) && (opc == OPC_OP_IMM);
    is_load   = (instr_in[1:0] == 2'b11) && (opc == OPC_LOAD);
    is_store  = (instr_in[1:0] == 2'b11) && (opc == OPC_STORE);
    is_branch = (instr_in[1:0] == 2'b11) && (opc == OPC_BRANCH);
    is_jal    = (instr_in[1:0] == 2'b11) && (opc == OPC_JAL);
    is_jalr   = (instr_in[1:0] == 2'b11) && (opc == OPC_JALR);
    is_lui    = (instr_in[1:0] == 2'b11) && (opc == OPC_LUI);
    is_auipc  = (instr_in[1:0] == 2'b11) && (opc == OPC_AUIPC);
    is_fence  = (instr_in[1:0] == 2'b11) && (opc == OPC_MISC_MEM);
    is_system = (instr_in[1:0] == 2'b11) && (opc == OPC_SYSTEM);
    is_csr    = is_system && (f3 != F3_PRIV);
    is_shift  = is_op_imm && ((f3 == F3_SLL) || (f3 == F3_SRL_SRA));

    illegal = !(is_op || is_op_imm || is_load || is_store || is_branch ||
                is_jal || is_jalr || is_lui || is_auipc || is_fence || is_system);
    if (is_op && !((f7 == F7_BASE) ||
                   ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))) ||
                   ((f7 == F7_MULDIV) && (EN_M != 0))))
      illegal = 1'b1;
    if (is_shift && !((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_SRL_SRA))))
      illegal = 1'b1;
    if (is_load && ((f3 == F3_RSV_011) || (f3 == F3_RSV_110) || (f3 == F3_RSV_111)))
      illegal = 1'b1;
    if (is_store && (f3[2] || (f3 == F3_RSV_011)))
      illegal = 1'b1;
    if (is_branch && ((f3 == F3_RSV_010) || (f3 == F3_RSV_011)))
      illegal = 1'b1;
    if (is_jalr && (f3 != F3_ADD_SUB))
      illegal = 1'b1;
    if (is_csr && (EN_CSR == 0))
      illegal = 1'b1;
    ok = !illegal;

    // Legality already rejects funct7=0000001 when EN_M=0.
    is_md = is_op && (f7 == F7_MULDIV) && ok;

    bundle_out               = '0;
    bundle_out.rs1_addr      = instr_in[19:15];
    bundle_out.rs2_addr      = instr_in[24:20];
    bundle_out.rd_addr       = instr_in[11:7];
    bundle_out.alu_opcode[2:0] = f3;
    bundle_out.alu_opcode[3] = (is_op && f7[5]) || (is_op_imm && (f3 == F3_SRL_SRA) && instr_in[30]);
    bundle_out.muldiv_en     = is_md;
    bundle_out.muldiv_op     = is_md ? f3 : 3'b000;
    bundle_out.load_size     = f3[1:0];
    bundle_out.load_unsigned = f3[2];
    bundle_out.mem_rd_req    = is_load && ok;
    bundle_out.mem_wr_req    = is_store && ok;
    bundle_out.alu_src       = opc[3];
    bundle_out.iadder_src    = is_load || is_store || is_jalr;
    bundle_out.rf_wr_en      = ok && (instr_in[11:7] != 5'd0) &&
                               (is_lui || is_auipc || is_jal || is_jalr ||
                                is_op || is_op_imm || is_load || is_csr);
    bundle_out.csr_wr_en     = is_csr && ok;
    bundle_out.csr_op        = f3;
    bundle_out.is_branch     = is_branch && ok;
    bundle_out.is_jal        = is_jal && ok;
    bundle_out.is_jalr       = is_jalr && ok;
    bundle_out.is_fence      = is_fence && ok;
    bundle_out.illegal       = illegal;

    // Classes are mutually exclusive, so these chains equal the per-bit OR forms.
    if (is_load || is_auipc)     bundle_out.wb_mux_sel = WB_LU;
    else if (is_jal || is_jalr)  bundle_out.wb_mux_sel = WB_PC4;
    else if (is_csr)             bundle_out.wb_mux_sel = WB_CSR;
    else if (is_md)              bundle_out.wb_mux_sel = WB_MULDIV;
    else                         bundle_out.wb_mux_sel = WB_ALU;

    if (is_op_imm || is_load || is_jalr) bundle_out.imm_type = IMM_I;
    else if (is_store)                   bundle_out.imm_type = IMM_S;
    else if (is_branch)                  bundle_out.imm_type = IMM_B;
    else if (is_lui || is_auipc)         bundle_out.imm_type = IMM_U;
    else if (is_jal)                     bundle_out.imm_type = IMM_J;
    else if (is_csr)                     bundle_out.imm_type = IMM_CSR;
    else                                 bundle_out.imm_type = IMM_NONE;
  end

endmodule

// File: rtl/msrv32_dec_pipe.sv
// msrv32_dec_pipe: registered, valid/ready decode stage with a one-entry skid.
// Input side: instr_in/pc_in/in_valid_in, in_ready_out (= skid empty).
// Output side: decoded bundle + pc_out, out_valid_out/out_ready_in.
// flush_in drops the held bundle, the skid and the instruction presented.
`timescale 1ns/1ps
module msrv32_dec_pipe
  import msrv32_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned EN_M   = 1,
  parameter int unsigned EN_CSR = 1
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            in_valid_in,
  output logic            in_ready_out,
  input  logic            flush_in,
  output logic            out_valid_out,
  input  logic            out_ready_in,
  output logic [PC_W-1:0] pc_out,
  output logic [4:0]      rs1_addr_out,
  output logic [4:0]      rs2_addr_out,
  output logic [4:0]      rd_addr_out,
  output logic [3:0]      alu_opcode_out,
  output logic            muldiv_en_out,
  output logic [2:0]      muldiv_op_out,
  output logic [1:0]      load_size_out,
  output logic            load_unsigned_out,
  output logic            mem_rd_req_out,
  output logic            mem_wr_req_out,
  output logic            alu_src_out,
  output logic            iadder_src_out,
  output logic            rf_wr_en_out,
  output logic            csr_wr_en_out,
  output logic [2:0]      csr_op_out,
  output logic [2:0]      wb_mux_sel_out,
  output logic [2:0]      imm_type_out,
  output logic            is_branch_out,
  output logic            is_jal_out,
  output logic            is_jalr_out,
  output logic            is_fence_out,
  output logic            illegal_instr_out
);

  dec_bundle_t     dec_b;
  dec_bundle_t     out_d, out_q, skid_d, skid_q;
  logic [PC_W-1:0] out_pc_d, out_pc_q, skid_pc_d, skid_pc_q;
  logic            out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  logic            accept;

  msrv32_dec_core #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_core (
    .instr_in   (instr_in),
    .bundle_out (dec_b)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    accept       = in_valid_in && !skid_valid_q;

    if (flush_in) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_in) begin
      // Output slot frees up: the older skid entry wins over the input,
      // and input is never accepted while the skid is occupied.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_d       = dec_b;
        out_pc_d    = pc_in;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec_b;
      skid_pc_d    = pc_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready_out      = !skid_valid_q;
  assign out_valid_out     = out_valid_q;
  assign pc_out            = out_pc_q;
  assign rs1_addr_out      = out_q.rs1_addr;
  assign rs2_addr_out      = out_q.rs2_addr;
  assign rd_addr_out       = out_q.rd_addr;
  assign alu_opcode_out    = out_q.alu_opcode;
  assign muldiv_en_out     = out_q.muldiv_en;
  assign muldiv_op_out     = out_q.muldiv_op;
  assign load_size_out     = out_q.load_size;
  assign load_unsigned_out = out_q.load_unsigned;
  assign mem_rd_req_out    = out_q.mem_rd_req;
  assign mem_wr_req_out    = out_q.mem_wr_req;
  assign alu_src_out       = out_q.alu_src;
  assign iadder_src_out    = out_q.iadder_src;
  assign rf_wr_en_out      = out_q.rf_wr_en;
  assign csr_wr_en_out     = out_q.csr_wr_en;
  assign csr_op_out        = out_q.csr_op;
  assign wb_mux_sel_out    = out_q.wb_mux_sel;
  assign imm_type_out      = out_q.imm_type;
  assign is_branch_out     = out_q.is_branch;
  assign is_jal_out        = out_q.is_jal;
  assign is_jalr_out       = out_q.is_jalr;
  assign is_fence_out      = out_q.is_fence;
  assign illegal_instr_out = out_q.illegal;

endmodule

// File: tb/tb_msrv32_dec_pipe.sv
// tb_msrv32_dec_pipe: scoreboard bench for msrv32_dec_pipe. Two instances
// share stimulus: u_dut (EN_M=1, EN_CSR=1) and u_nom (EN_M=0, EN_CSR=0).
`timescale 1ns/1ps
module tb_msrv32_dec_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu;
    logic        rf_we, csr_we, ill, md_en, mrd, mwr;
    logic [2:0]  wb, imm;
    logic [3:0]  cls;   // {is_branch, is_jal, is_jalr, is_fence}
    logic        full;  // 0: wb/imm are don't-care (illegal encodings)
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        in_valid_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        out_ready_in = 1'b0;

  logic        in_ready_out, out_valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [3:0]  alu_opcode_out;
  logic        muldiv_en_out, load_unsigned_out, mem_rd_req_out, mem_wr_req_out;
  logic [2:0]  muldiv_op_out, csr_op_out, wb_mux_sel_out, imm_type_out;
  logic [1:0]  load_size_out;
  logic        alu_src_out, iadder_src_out, rf_wr_en_out, csr_wr_en_out;
  logic        is_branch_out, is_jal_out, is_jalr_out, is_fence_out, illegal_instr_out;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_pc;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [3:0]  n_alu;
  logic        n_md_en, n_lu, n_mrd, n_mwr, n_alu_src, n_iadd, n_rf_we, n_csr_we;
  logic [2:0]  n_md_op, n_csr_op, n_wb, n_imm;
  logic [1:0]  n_ls;
  logic        n_br, n_jal, n_jalr, n_fence, n_ill;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  logic nq[$];

  always #5 clk = ~clk;

  msrv32_dec_pipe #(.PC_W(32), .EN_M(1), .EN_CSR(1)) u_dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .instr_in(instr_in), .pc_in(pc_in), .in_valid_in(in_valid_in),
    .in_ready_out(in_ready_out), .flush_in(flush_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in), .pc_out(pc_out),
    .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out),
    .alu_opcode_out(alu_opcode_out), .muldiv_en_out(muldiv_en_out),
    .muldiv_op_out(muldiv_op_out), .load_size_out(load_size_out),
    .load_unsigned_out(load_unsigned_out), .mem_rd_req_out(mem_rd_req_out),
    .mem_wr_req_out(mem_wr_req_out), .alu_src_out(alu_src_out),
    .iadder_src_out(iadder_src_out), .rf_wr_en_out(rf_wr_en_out),
    .csr_wr_en_out(csr_wr_en_out), .csr_op_out(csr_op_out),
    .wb_mux_sel_out(wb_mux_sel_out), .imm_type_out(imm_type_out),
    .is_branch_out(is_branch_out), .is_jal_out(is_jal_out), .is_jalr_out(is_jalr_out),
    .is_fence_out(is_fence_out), .illegal_instr_out(illegal_instr_out)
  );

  msrv32_dec_pipe #(.PC_W(32), .EN_M(0), .EN_CSR(0)) u_nom (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .instr_in(instr_in), .pc_in(pc_in), .in_valid_in(in_valid_in),
    .in_ready_out(n_in_ready), .flush_in(flush_in),
    .out_valid_out(n_out_valid), .out_ready_in(out_ready_in), .pc_out(n_pc),
    .rs1_addr_out(n_rs1), .rs2_addr_out(n_rs2), .rd_addr_out(n_rd),
    .alu_opcode_out(n_alu), .muldiv_en_out(n_md_en), .muldiv_op_out(n_md_op),
    .load_size_out(n_ls), .load_unsigned_out(n_lu), .mem_rd_req_out(n_mrd),
    .mem_wr_req_out(n_mwr), .alu_src_out(n_alu_src), .iadder_src_out(n_iadd),
    .rf_wr_en_out(n_rf_we), .csr_wr_en_out(n_csr_we), .csr_op_out(n_csr_op),
    .wb_mux_sel_out(n_wb), .imm_type_out(n_imm), .is_branch_out(n_br),
    .is_jal_out(n_jal), .is_jalr_out(n_jalr), .is_fence_out(n_fence),
    .illegal_instr_out(n_ill)
  );

  function automatic logic [31:0] vec_instr(input int i);
    case (i)
      0:  return 32'h002081B3; // add  x3,x1,x2
      1:  return 32'h4032D293; // srai x5,x5,3
      2:  return 32'h40329293; // slli with instr[30]=1 (illegal)
      3:  return 32'h023100B3; // mul  x1,x2,x3
      4:  return 32'h00000013; // addi x0,x0,0
      5:  return 32'h0000B083; // load funct3=011 (illegal)
      6:  return 32'h300110F3; // csrrw x1,0x300,x2
      7:  return 32'h0080A203; // lw   x4,8(x1)
      8:  return 32'h0020A223; // sw   x2,4(x1)
      9:  return 32'h008000EF; // jal  x1,+8
      default: return 32'h00208463; // beq x1,x2,+8
    endcase
  endfunction

  //                      pc     rd    rs1   rs2   alu      rf   csr  ill  md   mrd  mwr  wb      imm     cls      full
  function automatic exp_t vec_exp(input int i);
    case (i)
      0:  return '{32'h0, 5'd3, 5'd1, 5'd2, 4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b000, 4'b0000, 1'b1};
      1:  return '{32'h0, 5'd5, 5'd5, 5'd3, 4'b1101, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b001, 4'b0000, 1'b1};
      2:  return '{32'h0, 5'd5, 5'd5, 5'd3, 4'b0001, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'b000, 3'b000, 4'b0000, 1'b0};
      3:  return '{32'h0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 3'b100, 3'b000, 4'b0000, 1'b1};
      4:  return '{32'h0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b001, 4'b0000, 1'b1};
      5:  return '{32'h0, 5'd1, 5'd1, 5'd0, 4'b0011, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'b000, 3'b000, 4'b0000, 1'b0};
      6:  return '{32'h0, 5'd1, 5'd2, 5'd0, 4'b0001, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 3'b010, 3'b110, 4'b0000, 1'b1};
      7:  return '{32'h0, 5'd4, 5'd1, 5'd8, 4'b0010, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 3'b001, 3'b001, 4'b0000, 1'b1};
      8:  return '{32'h0, 5'd4, 5'd1, 5'd2, 4'b0010, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'b000, 3'b010, 4'b0000, 1'b1};
      9:  return '{32'h0, 5'd1, 5'd0, 5'd8, 4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'b011, 3'b101, 4'b0100, 1'b1};
      default: return '{32'h0, 5'd8, 5'd1, 5'd2, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'b000, 3'b011, 4'b1000, 1'b1};
    endcase
  endfunction

  // Illegal on the EN_M=0 / EN_CSR=0 instance: slli-bad, mul, load-bad, csrrw.
  function automatic logic nom_ill(input int i);
    return (i == 2) || (i == 3) || (i == 5) || (i == 6);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One cycle of stimulus, starting 1ns after a posedge and ending 1ns after the next.
  task automatic step(input bit v, input int idx, input logic [31:0] pc,
                      input bit fl, input bit push, output bit acc);
    logic rdy;
    exp_t e;
    in_valid_in = v;
    instr_in    = v ? vec_instr(idx) : 32'h0;
    pc_in       = pc;
    flush_in    = fl;
    rdy         = in_ready_out;
    @(posedge clk);
    #1;
    acc = v && rdy;
    if (acc && push && !fl && !rst) begin
      e    = vec_exp(idx);
      e.pc = pc;
      q.push_back(e);
      nq.push_back(nom_ill(idx));
    end
    in_valid_in = 1'b0;
    flush_in    = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (!rst && out_valid_out && out_ready_in) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got pc=%h want no output", pc_out);
      end else begin
        e = q.pop_front();
        a = '{pc_out, rd_addr_out, rs1_addr_out, rs2_addr_out, alu_opcode_out,
              rf_wr_en_out, csr_wr_en_out, illegal_instr_out, muldiv_en_out,
              mem_rd_req_out, mem_wr_req_out, wb_mux_sel_out, imm_type_out,
              {is_branch_out, is_jal_out, is_jalr_out, is_fence_out}, e.full};
        if (!e.full) begin
          a.wb  = e.wb;
          a.imm = e.imm;
        end
        if (a !== e) begin
          bad++;
          $display("FAIL bundle pc=%h: got %h want %h", e.pc, a, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic want;
    if (!rst && n_out_valid && out_ready_in) begin
      total++;
      if (nq.size() == 0) begin
        bad++;
        $display("FAIL nom_unexpected_output: got pc=%h want no output", n_pc);
      end else begin
        want = nq.pop_front();
        if ((n_ill !== want) || (want && (n_rf_we || n_md_en || n_csr_we))) begin
          bad++;
          $display("FAIL nom_illegal pc=%h: got ill=%b rf=%b md=%b csr=%b want ill=%b",
                   n_pc, n_ill, n_rf_we, n_md_en, n_csr_we, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          k;
    int          seq[4];
    logic [31:0] pc;
    seq = '{0, 1, 3, 7};
    pc  = 32'h100;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid_out}, 32'h0);
    chk("rst_in_ready",  {31'b0, in_ready_out}, 32'h1);
    chk("rst_illegal",   {31'b0, illegal_instr_out}, 32'h0);
    chk("rst_bundle",    {pc_out[15:0], 5'b0, rd_addr_out, alu_opcode_out, rf_wr_en_out,
                          wb_mux_sel_out}, 32'h0);
    rst = 1'b0;

    // Full-throughput stream of every vector, one per cycle.
    out_ready_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, i, pc, 1'b0, 1'b1, acc);
      if (i == 0) begin
        chk("latency_valid", {31'b0, out_valid_out}, 32'h1);
        chk("latency_pc", pc_out, pc);
      end
      chk("stream_accept", {31'b0, acc}, 32'h1);
      pc += 4;
    end
    step(1'b0, 0, pc, 1'b0, 1'b0, acc);
    step(1'b0, 0, pc, 1'b0, 1'b0, acc);

    // Back-pressure: output held 3 cycles while 4 instructions are offered.
    out_ready_in = 1'b0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) out_ready_in = 1'b1;
      if (c == 2) chk("bp_in_ready_low", {31'b0, in_ready_out}, 32'h0);
      step(k < 4, seq[k % 4], pc, 1'b0, 1'b1, acc);
      if (acc) begin
        k++;
        pc += 4;
      end
      if (c >= 2 && c <= 5) chk("bp_out_valid", {31'b0, out_valid_out}, 32'h1);
    end
    chk("bp_all_accepted", k, 32'd4);

    // Flush with the skid full and a new instruction presented.
    out_ready_in = 1'b0;
    step(1'b1, 4, pc, 1'b0, 1'b0, acc); pc += 4;
    step(1'b1, 10, pc, 1'b0, 1'b0, acc); pc += 4;
    chk("fl_skid_full", {31'b0, in_ready_out}, 32'h0);
    step(1'b1, 0, pc, 1'b1, 1'b0, acc); pc += 4;
    chk("fl_out_valid", {31'b0, out_valid_out}, 32'h0);
    chk("fl_in_ready", {31'b0, in_ready_out}, 32'h1);

    // Flush with in_ready=1: the presented instruction is dropped.
    step(1'b1, 8, pc, 1'b0, 1'b0, acc); pc += 4;
    step(1'b1, 1, pc, 1'b1, 1'b0, acc); pc += 4;
    chk("fl2_out_valid", {31'b0, out_valid_out}, 32'h0);
    out_ready_in = 1'b1;
    step(1'b0, 0, pc, 1'b0, 1'b0, acc);
    chk("fl2_stays_empty", {31'b0, out_valid_out}, 32'h0);
    step(1'b1, 9, pc, 1'b0, 1'b1, acc); pc += 4;
    step(1'b0, 0, pc, 1'b0, 1'b0, acc);

    // Reset mid-operation, with flush and valid asserted alongside.
    out_ready_in = 1'b0;
    step(1'b1, 6, pc, 1'b0, 1'b0, acc); pc += 4;
    step(1'b1, 3, pc, 1'b0, 1'b0, acc); pc += 4;
    rst = 1'b1;
    step(1'b1, 7, pc, 1'b1, 1'b0, acc); pc += 4;
    chk("mid_rst_out_valid", {31'b0, out_valid_out}, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready_out}, 32'h1);
    chk("mid_rst_bundle", {rd_addr_out, illegal_instr_out, rf_wr_en_out, pc_out[24:0]}, 32'h0);
    rst = 1'b0;
    out_ready_in = 1'b1;
    step(1'b1, 6, pc, 1'b0, 1'b1, acc); pc += 4;
    repeat (3) step(1'b0, 0, pc, 1'b0, 1'b0, acc);

    chk("scoreboard_drained", q.size(), 32'd0);
    chk("nom_scoreboard_drained", nq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_dec_pipe.md
# msrv32_dec_pipe

Registered, handshaked successor to the combinational instruction decoder. It sits between fetch and the register-read/execute stage. It accepts one 32-bit instruction plus its PC per cycle over valid/ready, decodes it into the control bundle, and presents the bundle registered one cycle later. A one-entry skid buffer keeps full throughput under back-pressure. It adds optional M-extension decode, strict funct7 legality checks, x0-write suppression and pipeline flush.

## Interface
Parameters:
- PC_W, 32, width of the PC carried alongside the instruction
- EN_M, 1, 1 = decode MUL/DIV (OP with funct7=0000001); 0 = those encodings are illegal
- EN_CSR, 1, 1 = decode CSR ops; 0 = SYSTEM with funct3≠000 is illegal

Ports (clock and reset: one clock; reset is synchronous and active-high):
- ms_riscv32_mp_clk_in  in  1  clock
- ms_riscv32_mp_rst_in  in  1  synchronous active-high reset
- instr_in  in  32  instruction word
- pc_in  in  PC_W  PC of instr_in
- in_valid_in  in  1  instr_in/pc_in valid
- in_ready_out  out  1  stage can accept
- flush_in  in  1  discard all held and incoming instructions
- out_valid_out  out  1  decoded bundle valid
- out_ready_in  in  1  downstream accepts the bundle
- pc_out  out  PC_W  PC of the decoded instruction
- rs1_addr_out, rs2_addr_out, rd_addr_out  out  5 each  instr[19:15], [24:20], [11:7]
- alu_opcode_out  out  4  {bit3, funct3}
- muldiv_en_out  out  1  M-extension op
- muldiv_op_out  out  3  funct3 of the M op
- load_size_out  out  2  funct3[1:0]
- load_unsigned_out  out  1  funct3[2]
- mem_rd_req_out, mem_wr_req_out  out  1 each  load / store
- alu_src_out, iadder_src_out  out  1 each  same meaning as the current decoder
- rf_wr_en_out, csr_wr_en_out  out  1 each  write enables
- csr_op_out  out  3  funct3
- wb_mux_sel_out  out  3  write-back select
- imm_type_out  out  3  immediate type
- is_branch_out, is_jal_out, is_jalr_out, is_fence_out  out  1 each  control-flow / fence class
- illegal_instr_out  out  1  illegal encoding

## Operation
- Opcode classes (instr[6:2]): OP 01100, OP_IMM 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101, MISC_MEM 00011, SYSTEM 11100.
- Illegal when any of the following holds:
  - instr[1:0]≠11, or the opcode matches none of the classes.
  - OP with funct7 not in {0000000, 0100000 with funct3∈{000,101}, 0000001 with EN_M}.
  - OP_IMM shift (funct3 001/101) with instr[31:25] not 0000000, or not 0100000 with funct3=101.
  - LOAD with funct3∈{011,110,111}, or STORE with funct3[2]=1 or funct3=011.
  - BRANCH with funct3∈{010,011}, or JALR with funct3≠000.
  - SYSTEM CSR when EN_CSR=0.
- When illegal: rf_wr_en, csr_wr_en, mem_rd_req, mem_wr_req, muldiv_en and is_* outputs are all 0. illegal_instr_out=1 and pc_out remain valid.
- alu_opcode[3]:
  - OP: funct7[5].
  - OP_IMM: instr[30] only when funct3=101; otherwise 0.
  - All other classes: 0.
- wb_mux_sel:
  - bit0 = load|auipc|jal|jalr
  - bit1 = csr|jal|jalr
  - bit2 = muldiv
- imm_type:
  - bit0 = op_imm|load|jalr|branch|jal
  - bit1 = store|branch|csr
  - bit2 = lui|auipc|jal|csr
- rf_wr_en = (lui|auipc|jal|jalr|op|op_imm|load|csr) & (rd≠0).
- csr = SYSTEM & funct3≠000.
- Misalignment detection is not done here; the execute-stage checker owns it.

## Timing
- Reset values:
  - out_valid_out 0, in_ready_out 1, skid empty.
  - All bundle outputs 0; illegal_instr_out 0.
- Latency: an instruction accepted in cycle N (in_valid & in_ready) appears with out_valid_out=1 in cycle N+1.
- Transfer occurs when out_valid & out_ready. Bundle outputs are stable while out_valid=1 and out_ready=0.
- Skid buffer: in_ready_out = ~skid_valid, registered.
- If the output is held and the input is accepted, the instruction is decoded into the skid. When the output drains, the skid moves to the output and in_ready returns to 1 next cycle.
- Full throughput: one instruction per cycle while out_ready=1.
- flush_in:
  - Next cycle, out_valid=0 and the skid is empty.
  - The instruction presented in the flush cycle is dropped.
  - in_ready_out=1 the cycle after.
- Flush has priority over accept and transfer.
- Reset mid-operation returns all state to reset values on the next edge; flush during reset is a no-op.
- Order is strictly preserved; no instruction is duplicated or lost except by flush.

## Structure
- Package msrv32_pkg holds:
  - opcode class constants and funct3/funct7 constants
  - wb_mux_sel and imm_type encodings
  - a packed struct dec_bundle_t for the registered bundle
- Sub-module msrv32_dec_core: purely combinational instr → dec_bundle_t with EN_M/EN_CSR parameters, instantiated once. The top holds the output register, skid and handshake.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready=1 → next cycle: out_valid=1, alu_opcode=0000, rf_wr_en=1, rd=3, illegal=0.
- SRAI x5,x5,3 (0x4032D293) → alu_opcode=1101, imm_type=001. SLLI with instr[30]=1 (0x40329293) → illegal=1, rf_wr_en=0.
- MUL x1,x2,x3 (0x023100B3):
  - EN_M=1 → muldiv_en=1, wb_mux_sel=100.
  - EN_M=0 → illegal=1.
- Back-pressure: stream 4 instructions with out_ready=0 for 3 cycles → in_ready drops after 2 are held. All 4 emerge in order once out_ready=1, one per cycle.
- Flush while the skid is full and in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed instructions never appear.
- ADDI x0,x0,0 (0x00000013) → rf_wr_en=0, illegal=0. LW with funct3=011 (0x0000B083) → illegal=1, mem_rd_req=0.
